pio_edge_irq: RTL

Parametrised Avalon-MM input PIO that generalises the existing two-bit button PIO. It adds configurable width, a synchroniser, a per-bit debounce filter, per-bit rising/falling edge selection and write-1-to-clear edge capture. It sits on the system Avalon-MM interconnect as a slave and drives one level interrupt to the processor. Typical loads are push-buttons, DIP switches and slow status lines from the front-end boards.

---
 rtl/pio_edge_irq_pkg.sv | 16 +
 rtl/pio_edge_irq_if.sv | 20 ++
 rtl/pio_debounce_bit.sv | 52 +++++
 rtl/pio_edge_irq.sv | 86 ++++++++
 4 files changed

// File: rtl/pio_edge_irq_pkg.sv
// Shared constants and helpers for the edge-capturing input PIO.
package pio_pkg;

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_RAW  = 3'd1;
    localparam logic [2:0] ADDR_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE = 3'd3;
    localparam logic [2:0] ADDR_RISE = 3'd4;
    localparam logic [2:0] ADDR_FALL = 3'd5;

    // Counter must reach DEBOUNCE_CYCLES-1; keep at least one bit for the bypass case.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/pio_edge_irq_if.sv
// Avalon-MM slave port of the input PIO.
interface pio_edge_irq_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/pio_debounce_bit.sv
// One input bit: synchroniser chain followed by a hold-time debounce filter.
module pio_debounce_bit
    import pio_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic in_bit,
    output logic sync_bit,
    output logic stable_bit
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], in_bit};
    end

    assign sync_bit = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk) begin
                if (reset) stable_bit <= 1'b0;
                else       stable_bit <= sync_bit;
            end
        end else begin : g_filter
            localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt;

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt        <= '0;
                    stable_bit <= 1'b0;
                end else if (sync_bit == stable_bit) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    stable_bit <= sync_bit;
                    cnt        <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/pio_edge_irq.sv
// Parametrised Avalon-MM input PIO with debounce, selectable edge capture and level irq.
module pio_edge_irq
    import pio_pkg::*;
#(
    parameter int unsigned      WIDTH           = 8,
    parameter int unsigned      SYNC_STAGES     = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = 1000,
    parameter logic [WIDTH-1:0] RISE_EN_RESET   = '1,
    parameter logic [WIDTH-1:0] FALL_EN_RESET   = '0
) (
    input  logic             clk,
    input  logic             reset,
    pio_edge_irq_if.slave    bus,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] edge_event;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] clr_mask;
    logic             wr;
    logic [31:0]      rd_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_db (
            .clk        (clk),
            .reset      (reset),
            .in_bit     (in_port[i]),
            .sync_bit   (sync[i]),
            .stable_bit (stable[i])
        );
    end

    assign wr         = bus.chipselect & ~bus.write_n;
    assign wdata      = bus.writedata[WIDTH-1:0];
    assign edge_event = (stable & ~stable_d & rise_en) | (~stable & stable_d & fall_en);
    assign clr_mask   = (wr && bus.address == ADDR_EDGE) ? wdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_d     <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
            rise_en      <= RISE_EN_RESET;
            fall_en      <= FALL_EN_RESET;
        end else begin
            stable_d     <= stable;
            // Event is OR'd in after the clear so a same-cycle W1C never drops it.
            edge_capture <= edge_event | (edge_capture & ~clr_mask);
            if (wr && bus.address == ADDR_MASK) irq_mask <= wdata;
            if (wr && bus.address == ADDR_RISE) rise_en  <= wdata;
            if (wr && bus.address == ADDR_FALL) fall_en  <= wdata;
        end
    end

    always_comb begin
        rd_next = '0;
        case (bus.address)
            ADDR_DATA: rd_next[WIDTH-1:0] = stable;
            ADDR_RAW:  rd_next[WIDTH-1:0] = sync;
            ADDR_MASK: rd_next[WIDTH-1:0] = irq_mask;
            ADDR_EDGE: rd_next[WIDTH-1:0] = edge_capture;
            ADDR_RISE: rd_next[WIDTH-1:0] = rise_en;
            ADDR_FALL: rd_next[WIDTH-1:0] = fall_en;
            default:   rd_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) bus.readdata <= '0;
        else       bus.readdata <= rd_next;
    end

    assign irq = |(edge_capture & irq_mask);

endmodule
